// File: rtl/data_memory.sv
// Single-port 16-bit word memory with registered read data and synchronous reset.
// Latency: read data appears one clock after read_enable is sampled; writes land on the same edge.
// Backpressure: none; every request completes in the cycle it is sampled.
module data_memory #(
    parameter int unsigned     DEPTH      = 256,
    parameter logic [15:0]     INIT_VALUE = 16'h0000
) (
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] read_data_out
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    logic [15:0]   mem [DEPTH] = '{default: INIT_VALUE};
    logic [15:0]   read_data_q = INIT_VALUE;
    logic [AW-1:0] idx;
    logic          in_range;

    // 17-bit compare so DEPTH = 65536 treats every address as in range.
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign idx      = addr[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= INIT_VALUE;
            end
            read_data_q <= INIT_VALUE;
        end else begin
            if (write_enable && in_range) begin
                mem[idx] <= data_in;
            end
            // Non-blocking update gives read-before-write on a shared address.
            if (read_enable) begin
                read_data_q <= in_range ? mem[idx] : 16'h0000;
            end
        end
    end

    assign read_data_out = read_data_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH=256) with hand-computed expected read data.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] read_data_out;

    int checks = 0;
    int errors = 0;

    data_memory #(.DEPTH(256), .INIT_VALUE(16'h0000)) dut (
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .data_in      (data_in),
        .read_data_out(read_data_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [15:0] a, input logic [15:0] d);
        write_enable = we;
        read_enable  = re;
        addr         = a;
        data_in      = d;
    endtask

    initial begin
        #1;
        check_val("power_up", read_data_out, 16'h0000);

        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        step();
        check_val("after_reset", read_data_out, 16'h0000);
        reset = 1'b0;

        drive(1'b0, 1'b1, 16'h0000, 16'h0000);
        step();
        check_val("post_reset_read", read_data_out, 16'h0000);

        drive(1'b1, 1'b0, 16'h0000, 16'h0666);
        step();
        step();
        drive(1'b0, 1'b1, 16'h0000, 16'h0000);
        step();
        check_val("write_then_read", read_data_out, 16'h0666);

        // Address change with no edge must not disturb the registered output.
        addr = 16'h0042;
        #2;
        check_val("no_comb_path", read_data_out, 16'h0666);

        drive(1'b0, 1'b0, 16'h0055, 16'h0000);
        step();
        check_val("hold_re0", read_data_out, 16'h0666);

        drive(1'b1, 1'b0, 16'h0100, 16'hBEEF);
        step();
        drive(1'b0, 1'b1, 16'h0100, 16'h0000);
        step();
        check_val("oor_read", read_data_out, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 16'h0000);
        step();
        check_val("oor_no_alias", read_data_out, 16'h0666);

        drive(1'b1, 1'b0, 16'h0005, 16'h1111);
        step();
        drive(1'b1, 1'b1, 16'h0005, 16'h2222);
        step();
        check_val("rbw_old", read_data_out, 16'h1111);
        drive(1'b0, 1'b1, 16'h0005, 16'h0000);
        step();
        check_val("rbw_new", read_data_out, 16'h2222);

        drive(1'b1, 1'b0, 16'h0003, 16'hABCD);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b1, 16'h0003, 16'h9999);
        step();
        check_val("reset_prio_out", read_data_out, 16'h0000);
        reset = 1'b0;
        drive(1'b0, 1'b1, 16'h0003, 16'h0000);
        step();
        check_val("reset_prio_mem3", read_data_out, 16'h0000);
        drive(1'b0, 1'b1, 16'h0005, 16'h0000);
        step();
        check_val("reset_clear_mem5", read_data_out, 16'h0000);
        drive(1'b0, 1'b1, 16'h0000, 16'h0000);
        step();
        check_val("reset_clear_mem0", read_data_out, 16'h0000);

        drive(1'b1, 1'b0, 16'h00FF, 16'h7FFE);
        step();
        drive(1'b1, 1'b0, 16'h0000, 16'h0001);
        step();
        drive(1'b0, 1'b1, 16'h00FF, 16'h0000);
        step();
        check_val("bound_top", read_data_out, 16'h7FFE);
        drive(1'b0, 1'b1, 16'h0000, 16'h0000);
        step();
        check_val("bound_zero", read_data_out, 16'h0001);

        drive(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        step();
        check_val("oor_ffff", read_data_out, 16'h0000);
        drive(1'b0, 1'b1, 16'h01FF, 16'h0000);
        step();
        check_val("oor_alias_top", read_data_out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, meaning the number of 16-bit words stored; the legal range is 2..65536 and the value SHALL be a power of two.
REQ-002 The module SHALL have parameter INIT_VALUE, default 16'h0000, meaning the value loaded into every word and into read_data_out on reset.
REQ-003 Port `clk`: input, 1 bit, the single clock; all state SHALL update on its rising edge only.
REQ-004 Port `reset`: input, 1 bit, synchronous and active-high.
REQ-005 Port `write_enable`: input, 1 bit, write strobe.
REQ-006 Port `read_enable`: input, 1 bit, read strobe.
REQ-007 Port `addr`: input, 16 bits, word address shared by reads and writes.
REQ-008 Port `data_in`: input, 16 bits, write data.
REQ-009 Port `read_data_out`: output, 16 bits, registered read data.
REQ-010 The positional port order SHALL be write_enable, read_enable, clk, reset, addr, data_in, read_data_out.

Function
REQ-011 Storage SHALL be DEPTH words of 16 bits, word-addressed, with no byte enables.
REQ-012 An address is in range when addr < DEPTH; the address index SHALL be addr[log2(DEPTH)-1:0].
REQ-013 Write: on a rising edge with reset=0, write_enable=1 and addr in range, mem[addr] SHALL take the value of data_in.
REQ-014 A write to an out-of-range address SHALL be ignored and SHALL leave memory unchanged.
REQ-015 Read: on a rising edge with reset=0 and read_enable=1, read_data_out SHALL take mem[addr], giving exactly 1 cycle of latency.
REQ-016 A read from an out-of-range address SHALL load 16'h0000 into read_data_out.
REQ-017 When read_enable=0, read_data_out SHALL hold its previous value.
REQ-018 Simultaneous read and write to the same address SHALL be read-before-write: read_data_out gets the old word, and the new word is visible on the next read.
REQ-019 Simultaneous read and write to different addresses SHALL both take effect in the same cycle.
REQ-020 There SHALL be no handshake, no stall and no busy flag; every request SHALL complete in the cycle it is sampled.
REQ-021 Input values between clock edges SHALL have no effect.
REQ-022 read_data_out SHALL NOT change combinationally with addr.

Reset
REQ-023 On a rising edge with reset=1, every memory word and read_data_out SHALL be set to INIT_VALUE (default 0x0000).
REQ-024 Reset SHALL take priority over write_enable and read_enable in the same cycle, so no write occurs and reset values win.
REQ-025 Reset asserted mid-operation SHALL discard any write or read sampled in that cycle.
REQ-026 For simulation, memory and read_data_out SHALL also start at INIT_VALUE before the first clock.

Verification
REQ-027 Post-reset read: reset=1 for 1 edge, then read_enable=1, addr=0x0000 -> read_data_out=0x0000 one cycle later.
REQ-028 Write then read: write_enable=1, addr=0x0000, data_in=0x0666 for 2 edges; then write_enable=0, read_enable=1 -> read_data_out=0x0666 after 1 edge.
REQ-029 Same-cycle read/write: mem[5]=0x1111; in one cycle set write_enable=1, read_enable=1, addr=5, data_in=0x2222 -> read_data_out=0x1111; the next read of addr 5 -> 0x2222.
REQ-030 Hold and out-of-range (DEPTH=256): after reading 0x0666, set read_enable=0 and change addr -> output stays 0x0666; write 0xBEEF to addr 0x0100 -> ignored, and a read of 0x0100 -> 0x0000.
REQ-031 Reset priority: write 0xABCD to addr 3; then assert reset with write_enable=1, data_in=0x9999 on addr 3 -> read of addr 3 returns 0x0000.
REQ-032 Boundary: write 0x7FFE to addr DEPTH-1 (0x00FF) and 0x0001 to addr 0 -> reads return 0x7FFE and 0x0001 with no aliasing between them.
